ov7670_stream_gen: RTL and testbench
====================================

# ov7670_stream_gen

Synthetic OV7670-style camera source: generates pclk/href/vsync/8-bit RGB565 byte stream with the same framing the capture path (OV7670 memory controller → frame buffer) expects. It replaces the physical sensor for loopback bring-up and self-test of the capture-to-VGA pipeline: outputs connect directly to the capture path's pclk/href/vsync/data inputs. Frame geometry and test patterns are parameter- and input-selectable.

## Interface
Parameters:
- H_ACTIVE, 320, active pixels per line; must be divisible by 8; max 640
- V_ACTIVE, 240, active lines per frame; max 480
- H_BLANK, 144, pclk periods of href-low per line
- VSYNC_LINES, 3, lines with vsync high
- V_BACK, 17, blank lines between vsync fall and first active line
- V_FRONT, 10, blank lines after last active line

Ports:
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- enable  in  1  run request, sampled at frame boundaries
- mode  in  2  pattern: 0 color bars, 1 gradient, 2 checker, 3 solid
- fixed_color  in  16  RGB565 value for mode 3
- pclk  out  1  generated pixel clock, clk/2
- href  out  1  line-valid, high during active bytes
- vsync  out  1  frame sync, active high
- data  out  8  pixel byte, high byte first
- busy  out  1  high while a frame is in progress
- frame_done  out  1  one-clk pulse at end of each frame

## Operation
- One clock domain; reset is asynchronous and active-high.
- pclk is a register toggling every clk. "Tick" = clk edge where pclk is 1 (pclk falling). href, vsync, data, counters, state update only on ticks, so they are stable around every pclk rising edge.
- LINE_LEN = 2*H_ACTIVE + H_BLANK ticks; h_cnt 0..LINE_LEN-1 (11 bits), wraps to 0 and advances v_cnt.
- States: IDLE → VSYNC (VSYNC_LINES lines) → VBACK (V_BACK lines) → ACTIVE (V_ACTIVE lines) → VFRONT (V_FRONT lines) → VSYNC if enable else IDLE. A state with zero lines is skipped.
- IDLE: outputs low except pclk (free-running); on tick with enable=1 → VSYNC, h_cnt=0, v_cnt=0, mode/fixed_color latched.
- vsync=1 exactly in VSYNC. href=1 only in ACTIVE with h_cnt < 2*H_ACTIVE. data=0 whenever href=0.
- Pixel x = h_cnt>>1 (10 bits), y = active line index (10 bits); h_cnt[0]=0 → data=pix[15:8], 1 → pix[7:0].
- Patterns (latched mode, no mid-frame change):
  - 0: 8 bars of H_ACTIVE/8 px: FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000 (bar index via counter, no divider).
  - 1: {x[8:4], y[7:2], frame_cnt[4:0]}.
  - 2: x[3]^y[3] ? FFFF : 0000.
  - 3: latched fixed_color.
- frame_cnt: 8-bit, increments at each frame_done, wraps 255→0.
- busy=1 in all states except IDLE. enable deassert mid-frame: current frame completes, then IDLE.

## Timing
- Reset (async, immediate): state IDLE, pclk=0, href=0, vsync=0, data=0, busy=0, frame_done=0, counters and frame_cnt=0. Release mid-frame restarts cleanly from IDLE; no partial frame resumes.
- pclk period 2 clk; data/href/vsync change only on pclk falling edge; setup = hold = 1 clk to pclk rise.
- enable=1 at an IDLE tick → vsync=1 and busy=1 after that edge.
- href first rises (VSYNC_LINES+V_BACK)*LINE_LEN ticks after vsync rises; high for 2*H_ACTIVE ticks per line.
- Frame length (VSYNC_LINES+V_BACK+V_ACTIVE+V_FRONT)*LINE_LEN ticks; back-to-back frames have no gap.
- frame_done: one clk high on tick ending last VFRONT line; same edge vsync rises (enable=1) or busy falls (enable=0).
- Line wrap and state change on same tick: h_cnt=0 and new state's outputs apply together.

## Test plan
- Reset/idle: enable=0, 1000 clk → pclk toggles every clk; href=vsync=data=busy=0.
- Defaults, mode 0, enable held: vsync high 2352 ticks; first href after 15680 ticks from vsync rise; first 4 bytes FF,FF; byte 80 (x=40) FF,E0; 240 href pulses of 640 ticks; frame 211680 ticks; frame_done once, next vsync same edge.
- Mode 2 / mode 3 fixed_color=ABCD: checker pixel (8,0)=FFFF, (0,0)=0000, (8,8)=0000; solid stream AB,CD repeated; mode change mid-frame has no effect until next frame.
- Mode 1 over 3 frames: pixel(16,4) = {5'd1,6'd1,frame_cnt}, B field 0,1,2 across frames.
- enable drop mid-ACTIVE → frame finishes, frame_done pulse, busy falls, no further vsync.
- Reset asserted mid-ACTIVE → all outputs 0 immediately; after release with enable=1, full frame from vsync rise, correct pattern bytes (capture path reproduces pattern in frame buffer).

Source files
------------

// File: rtl/ov7670_stream_gen.sv
// Synthetic OV7670-style camera source: pclk/href/vsync framing with an
// RGB565 byte stream of selectable test patterns, high byte first.
module ov7670_stream_gen #(
  parameter int H_ACTIVE    = 320,
  parameter int V_ACTIVE    = 240,
  parameter int H_BLANK     = 144,
  parameter int VSYNC_LINES = 3,
  parameter int V_BACK      = 17,
  parameter int V_FRONT     = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [1:0]  mode,
  input  logic [15:0] fixed_color,
  output logic        pclk,
  output logic        href,
  output logic        vsync,
  output logic [7:0]  data,
  output logic        busy,
  output logic        frame_done
);

  localparam logic [10:0] H_ACT2 = 11'(2 * H_ACTIVE);
  localparam logic [10:0] H_LAST = 11'(2 * H_ACTIVE + H_BLANK - 1);
  localparam logic [6:0]  BAR_LAST = 7'(H_ACTIVE / 8 - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_VSYNC, S_VBACK, S_ACTIVE, S_VFRONT
  } state_t;

  // Zero-line phases are skipped at compile time.
  localparam state_t S_START = (VSYNC_LINES > 0) ? S_VSYNC :
                               (V_BACK > 0) ? S_VBACK : S_ACTIVE;
  localparam state_t S_LAST  = (V_FRONT > 0) ? S_VFRONT : S_ACTIVE;

  state_t      state, state_nx;
  logic [10:0] h_cnt;
  logic [9:0]  v_cnt;
  logic [9:0]  v_last;
  logic [6:0]  bar_px;
  logic [2:0]  bar_idx;
  logic [7:0]  frame_cnt;
  logic [1:0]  mode_q;
  logic [15:0] color_q;
  logic [15:0] pix;
  logic        tick, line_end, state_end, frame_end;

  assign tick      = pclk;
  assign line_end  = (h_cnt == H_LAST);
  assign state_end = line_end && (v_cnt == v_last);
  assign frame_end = state_end && (state == S_LAST);

  always_comb begin
    v_last = '0;
    unique case (state)
      S_VSYNC:  v_last = 10'(VSYNC_LINES - 1);
      S_VBACK:  v_last = 10'(V_BACK - 1);
      S_ACTIVE: v_last = 10'(V_ACTIVE - 1);
      S_VFRONT: v_last = 10'(V_FRONT - 1);
      default:  v_last = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) pclk <= 1'b0;
    else       pclk <= ~pclk;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (tick) begin
      if (state == S_IDLE) begin
        if (enable) state_nx = S_START;
      end else if (frame_end) begin
        state_nx = enable ? S_START : S_IDLE;
      end else if (state_end) begin
        unique case (state)
          S_VSYNC:  state_nx = (V_BACK > 0) ? S_VBACK : S_ACTIVE;
          S_VBACK:  state_nx = S_ACTIVE;
          S_ACTIVE: state_nx = S_VFRONT;
          default:  state_nx = S_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_cnt      <= '0;
      v_cnt      <= '0;
      bar_px     <= '0;
      bar_idx    <= '0;
      frame_cnt  <= '0;
      mode_q     <= '0;
      color_q    <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= tick && frame_end;
      if (tick) begin
        if (state == S_IDLE || line_end) begin
          h_cnt   <= '0;
          bar_px  <= '0;
          bar_idx <= '0;
        end else begin
          h_cnt <= h_cnt + 11'd1;
          // bar position tracks pixel boundaries so no divider is needed
          if (h_cnt[0] && h_cnt < H_ACT2) begin
            if (bar_px == BAR_LAST) begin
              bar_px  <= '0;
              bar_idx <= bar_idx + 3'd1;
            end else begin
              bar_px <= bar_px + 7'd1;
            end
          end
        end
        if (state == S_IDLE || state_end) v_cnt <= '0;
        else if (line_end)                v_cnt <= v_cnt + 10'd1;
        if ((state == S_IDLE || frame_end) && enable) begin
          mode_q  <= mode;
          color_q <= fixed_color;
        end
        if (frame_end) frame_cnt <= frame_cnt + 8'd1;
      end
    end
  end

  always_comb begin
    pix = '0;
    unique case (mode_q)
      2'd0: begin
        unique case (bar_idx)
          3'd0: pix = 16'hFFFF;
          3'd1: pix = 16'hFFE0;
          3'd2: pix = 16'h07FF;
          3'd3: pix = 16'h07E0;
          3'd4: pix = 16'hF81F;
          3'd5: pix = 16'hF800;
          3'd6: pix = 16'h001F;
          default: pix = 16'h0000;
        endcase
      end
      2'd1: pix = {h_cnt[9:5], v_cnt[7:2], frame_cnt[4:0]};
      2'd2: pix = (h_cnt[4] ^ v_cnt[3]) ? 16'hFFFF : 16'h0000;
      default: pix = color_q;
    endcase
  end

  always_comb begin
    href  = (state == S_ACTIVE) && (h_cnt < H_ACT2);
    vsync = (state == S_VSYNC);
    busy  = (state != S_IDLE);
    data  = '0;
    if (href) data = h_cnt[0] ? pix[7:0] : pix[15:8];
  end

endmodule

// File: tb/tb_ov7670_stream_gen.sv
// Directed bench for ov7670_stream_gen on a reduced frame geometry:
// 32x12 active, 8 blank pclks, 2/2/2 sync/back/front lines.
module tb_ov7670_stream_gen;

  localparam int FRAME_CLK = 2592;

  logic        clk, rst, enable;
  logic [1:0]  mode;
  logic [15:0] fixed_color;
  logic        pclk, href, vsync, busy, frame_done;
  logic [7:0]  data;

  int n_cmp = 0;
  int n_err = 0;

  int vs_len, href_first, href_cnt, href_badlen, fd_cnt, fd_pos, dz_bad;
  logic nxt_vs, busy_end, busy_pre;
  logic [7:0] bytes [12][64];
  logic [15:0] bar_col [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                              16'hF81F, 16'hF800, 16'h001F, 16'h0000};

  ov7670_stream_gen #(
    .H_ACTIVE(32), .V_ACTIVE(12), .H_BLANK(8),
    .VSYNC_LINES(2), .V_BACK(2), .V_FRONT(2)
  ) dut (
    .clk(clk), .reset(rst), .enable(enable), .mode(mode),
    .fixed_color(fixed_color), .pclk(pclk), .href(href),
    .vsync(vsync), .data(data), .busy(busy), .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Index 0 is the first negedge sample with vsync high.
  task automatic capture(input logic [1:0] m_mid, input logic [15:0] c_mid,
                         input logic en_mid);
    int k, line, col, hlen;
    logic pv, ph;
    k = 0;
    while (vsync !== 1'b1 && k < 10000) begin
      @(negedge clk);
      k++;
    end
    chk("vs_start", vsync, 1);
    for (int l = 0; l < 12; l++)
      for (int c = 0; c < 64; c++) bytes[l][c] = 8'hxx;
    vs_len = -1; href_first = -1; href_cnt = 0; href_badlen = 0;
    fd_cnt = 0; fd_pos = -1; dz_bad = 0; busy_pre = 1'b0;
    line = -1; col = 0; hlen = 0; pv = 1'b1; ph = 1'b0;
    for (int i = 1; i <= FRAME_CLK; i++) begin
      @(negedge clk);
      if (i == 1000) begin
        mode = m_mid; fixed_color = c_mid; enable = en_mid;
      end
      if (pv && !vsync && vs_len < 0) vs_len = i;
      if (href && !ph) begin
        href_cnt++; line++; col = 0; hlen = 0;
        if (href_first < 0) href_first = i;
      end
      if (href) hlen++;
      if (!href && ph && hlen != 128) href_badlen++;
      if (href && pclk && line >= 0 && line < 12 && col < 64) begin
        bytes[line][col] = data;
        col++;
      end
      if (!href && data !== 8'h00) dz_bad++;
      if (frame_done) begin fd_cnt++; fd_pos = i; end
      if (i == FRAME_CLK - 1) busy_pre = busy;
      pv = vsync; ph = href;
    end
    nxt_vs = vsync;
    busy_end = busy;
  endtask

  task automatic check_timing(input string tag, input logic exp_vs);
    chk({tag, "_vs_len"}, vs_len, 288);
    chk({tag, "_href_first"}, href_first, 576);
    chk({tag, "_href_cnt"}, href_cnt, 12);
    chk({tag, "_href_len"}, href_badlen, 0);
    chk({tag, "_fd_cnt"}, fd_cnt, 1);
    chk({tag, "_fd_pos"}, fd_pos, FRAME_CLK);
    chk({tag, "_next_vs"}, nxt_vs, exp_vs);
    chk({tag, "_data_zero"}, dz_bad, 0);
  endtask

  initial begin
    int tog, qb, bad;
    logic prev;
    logic [15:0] bc;
    logic [7:0] eb;

    rst = 1'b1; enable = 1'b0; mode = 2'd0; fixed_color = 16'h0000;
    repeat (3) @(negedge clk);
    chk("rst_pclk", pclk, 0);
    chk("rst_href", href, 0);
    chk("rst_vsync", vsync, 0);
    chk("rst_data", data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_fd", frame_done, 0);

    rst = 1'b0;
    prev = pclk; tog = 0; qb = 0;
    repeat (1000) begin
      @(negedge clk);
      if (pclk !== prev) tog++;
      prev = pclk;
      if (href || vsync || busy || frame_done || data != 8'd0) qb++;
    end
    chk("idle_toggle", tog, 1000);
    chk("idle_quiet", qb, 0);

    mode = 2'd1; enable = 1'b1;
    capture(2'd1, 16'h0000, 1'b1);
    check_timing("f1", 1'b1);
    chk("f1_p00_lo", bytes[0][1], 8'h00);
    chk("f1_p16_4_hi", bytes[4][32], 8'h08);
    chk("f1_p16_4_lo", bytes[4][33], 8'h20);

    capture(2'd1, 16'h0000, 1'b1);
    check_timing("f2", 1'b1);
    chk("f2_p00_lo", bytes[0][1], 8'h01);
    chk("f2_p16_4_lo", bytes[4][33], 8'h21);

    capture(2'd0, 16'h0000, 1'b1);
    check_timing("f3", 1'b1);
    chk("f3_p16_4_hi", bytes[4][32], 8'h08);
    chk("f3_p16_4_lo", bytes[4][33], 8'h22);
    chk("f3_p31_11_lo", bytes[11][63], 8'h42);

    capture(2'd2, 16'h0000, 1'b1);
    check_timing("f4", 1'b1);
    chk("f4_b0", bytes[0][0], 8'hFF);
    chk("f4_b1", bytes[0][1], 8'hFF);
    chk("f4_b8", bytes[0][8], 8'hFF);
    chk("f4_b9", bytes[0][9], 8'hE0);
    chk("f4_b48", bytes[5][48], 8'h00);
    chk("f4_b49", bytes[5][49], 8'h1F);
    bad = 0;
    for (int l = 0; l < 12; l++)
      for (int c = 0; c < 64; c++) begin
        bc = bar_col[c / 8];
        eb = c[0] ? bc[7:0] : bc[15:8];
        if (bytes[l][c] !== eb) bad++;
      end
    chk("f4_bars", bad, 0);

    capture(2'd3, 16'hABCD, 1'b1);
    check_timing("f5", 1'b1);
    chk("f5_p8_0", {bytes[0][16], bytes[0][17]}, 16'hFFFF);
    chk("f5_p0_0", {bytes[0][0], bytes[0][1]}, 16'h0000);
    chk("f5_p8_8", {bytes[8][16], bytes[8][17]}, 16'h0000);
    chk("f5_p0_8", {bytes[8][0], bytes[8][1]}, 16'hFFFF);

    capture(2'd3, 16'h1234, 1'b0);
    check_timing("f6", 1'b0);
    bad = 0;
    for (int l = 0; l < 12; l++)
      for (int c = 0; c < 64; c++)
        if (bytes[l][c] !== (c[0] ? 8'hCD : 8'hAB)) bad++;
    chk("f6_solid", bad, 0);
    chk("f6_busy_pre", busy_pre, 1);
    chk("f6_busy_end", busy_end, 0);
    qb = 0;
    repeat (500) begin
      @(negedge clk);
      if (vsync || busy) qb++;
    end
    chk("stop_quiet", qb, 0);

    mode = 2'd1; enable = 1'b1;
    qb = 0;
    while (vsync !== 1'b1 && qb < 10000) begin
      @(negedge clk);
      qb++;
    end
    chk("f7_vs", vsync, 1);
    repeat (700) @(negedge clk);
    chk("f7_href_mid", href, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_pclk", pclk, 0);
    chk("mid_rst_href", href, 0);
    chk("mid_rst_vsync", vsync, 0);
    chk("mid_rst_data", data, 0);
    chk("mid_rst_busy", busy, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    capture(2'd1, 16'h0000, 1'b1);
    check_timing("f8", 1'b1);
    chk("f8_p00", {bytes[0][0], bytes[0][1]}, 16'h0000);
    chk("f8_p16_4", {bytes[4][32], bytes[4][33]}, 16'h0820);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
